inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 157 +++++++++++++++
 tb/tb_inst_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//    Instruction fetch front end. A 32-bit fetch PC addresses a small
//    combinational instruction memory; each fetched {pc, inst} pair is pushed
//    into a 2-entry queue that feeds the decode stage through a valid/ready
//    handshake. Redirects from execute flush the queue and retarget the fetch
//    PC. A misaligned redirect traps the block in a sticky FAULT state that
//    only reset can clear.
//
// Ports:
//    clk            in   1   single clock, rising edge
//    rst            in   1   synchronous reset, active low
//    imem_offset    out  6   word index into instruction memory (fetch_pc[7:2])
//    imem_data      in   32  instruction word for imem_offset (combinational)
//    redirect_valid in   1   branch/jump redirect request
//    redirect_pc    in   32  redirect target byte address
//    out_valid      out  1   queue head holds a valid instruction
//    out_ready      in   1   decode accepts the head this cycle
//    out_inst       out  32  instruction at the queue head (0 when not valid)
//    out_pc         out  32  byte address of out_inst (0 when not valid)
//    fault          out  1   sticky: a misaligned redirect was received
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [5:0]  imem_offset,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic        fault
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   localparam int DEPTH = 2;

   state_t      state_q, state_d;
   logic        fault_q, fault_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  count_q, count_d;

   // Entry 0 is always the head; a pop shifts entry 1 down into entry 0.
   logic [31:0] pc_q   [DEPTH];
   logic [31:0] pc_d   [DEPTH];
   logic [31:0] inst_q [DEPTH];
   logic [31:0] inst_d [DEPTH];

   logic        pop;
   logic        push;
   logic        redirect_take;
   logic        redirect_misaligned;
   logic        wr_idx;

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem_offset = fetch_pc_q[7:2];
   assign out_valid   = (count_q != 2'd0);
   assign out_inst    = out_valid ? inst_q[0] : 32'h0;
   assign out_pc      = out_valid ? pc_q[0]   : 32'h0;
   assign fault       = fault_q;

   // ------------------------------------------------------------------------
   // Handshake / control decode
   // ------------------------------------------------------------------------
   assign pop                 = out_valid && out_ready;
   // Redirects are only honoured while running; in FAULT they are ignored.
   assign redirect_take       = (state_q == ST_RUN) && redirect_valid;
   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
   // A full queue may still accept a new word when the head leaves in the
   // same cycle, which is what keeps steady-state throughput at one per cycle.
   assign push                = (state_q == ST_RUN) && !redirect_valid &&
                                ((count_q != 2'd2) || pop);

   // Tail slot after the (optional) pop: the new word lands at index
   // count - pop, which is 1 only for {count=1,no pop} or {count=2,pop}.
   assign wr_idx = ((count_q == 2'd1) && !pop) || (count_q == 2'd2);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      fault_d    = fault_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         pc_d[i]   = pc_q[i];
         inst_d[i] = inst_q[i];
      end

      if (redirect_take) begin
         // Flush everything, including a head being popped this cycle.
         count_d = 2'd0;
         if (redirect_misaligned) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
         end else begin
            fetch_pc_d = redirect_pc;
         end
      end else if (state_q == ST_RUN) begin
         if (pop) begin
            pc_d[0]   = pc_q[1];
            inst_d[0] = inst_q[1];
         end
         if (push) begin
            if (wr_idx) begin
               pc_d[1]   = fetch_pc_q;
               inst_d[1] = imem_data;
            end else begin
               pc_d[0]   = fetch_pc_q;
               inst_d[0] = imem_data;
            end
            // Plain 32-bit add: wraps modulo 2^32.
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         fault_q    <= 1'b0;
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= 32'h0;
            inst_q[i] <= 32'h0;
         end
      end else begin
         state_q    <= state_d;
         fault_q    <= fault_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= pc_d[i];
            inst_q[i] <= inst_d[i];
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Scoreboard bench for inst_fetch. The reference model keeps the fetch
// address and a queue of the {pc, inst} pairs that have been fetched but not
// yet delivered; the monitor compares the DUT head against the queue front
// on the falling edge and pops on a handshake.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [5:0]  imem_offset;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        fault;

   logic [31:0] mem [64];
   assign imem_data = mem[imem_offset];

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_offset    (imem_offset),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [63:0] exp_q [$];
   logic [31:0] m_fetch;
   logic        m_fault;
   logic        popped;
   logic        chk_en;
   int          checks;
   int          failures;
   int          delivered;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic        exp_v;
         logic [63:0] item;
         exp_v = (exp_q.size() > 0) && !m_fault;
         check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
         check("fault", {31'b0, fault}, {31'b0, m_fault});
         check("imem_offset", {26'b0, imem_offset}, {26'b0, m_fetch[7:2]});
         if (exp_v) begin
            item = exp_q[0];
            check("out_pc", out_pc, item[63:32]);
            check("out_inst", out_inst, item[31:0]);
            if (out_ready) begin
               void'(exp_q.pop_front());
               popped = 1'b1;
               delivered++;
            end
         end else begin
            check("out_pc_idle", out_pc, 32'h0);
            check("out_inst_idle", out_inst, 32'h0);
         end
      end
   end

   // Drive one cycle of inputs, then advance the model by the edge just taken.
   task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      int occ;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      @(posedge clk);
      #1;
      if (!r) begin
         exp_q.delete();
         m_fetch = RESET_PC;
         m_fault = 1'b0;
      end else if (!m_fault && rv) begin
         exp_q.delete();
         if (rpc[1:0] != 2'b00) m_fault = 1'b1;
         else                   m_fetch = rpc;
      end else if (!m_fault) begin
         occ = exp_q.size() + (popped ? 1 : 0);
         if (occ < 2 || popped) begin
            exp_q.push_back({m_fetch, mem[m_fetch[7:2]]});
            m_fetch = m_fetch + 32'd4;
         end
      end
      popped = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, rdy);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      int d0;
      checks    = 0;
      failures  = 0;
      delivered = 0;
      chk_en    = 1'b0;
      popped    = 1'b0;
      m_fetch   = RESET_PC;
      m_fault   = 1'b0;
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h11 + i;

      // Sequential stream from reset with decode always ready.
      do_reset(2);
      d0 = delivered;
      idle(7, 1'b1);
      check("stream_count", delivered - d0, 6);

      // Back-pressure fills the queue, then drains without a gap.
      do_reset(1);
      idle(5, 1'b0);
      check("held_out_pc", out_pc, 32'h0);
      check("held_offset", {26'b0, imem_offset}, 32'd2);
      d0 = delivered;
      idle(3, 1'b1);
      check("drain_count", delivered - d0, 3);

      // Aligned redirect with a full queue, decode stalled.
      do_reset(1);
      idle(3, 1'b0);
      cyc(1'b1, 1'b1, 32'h14, 1'b0);
      idle(4, 1'b1);

      // Aligned redirect while the head is being popped.
      idle(2, 1'b0);
      cyc(1'b1, 1'b1, 32'h40, 1'b1);
      idle(3, 1'b1);

      // Misaligned redirect, then an ignored aligned redirect, then reset.
      cyc(1'b1, 1'b1, 32'h0000_0102, 1'b1);
      idle(3, 1'b1);
      cyc(1'b1, 1'b1, 32'h0, 1'b1);
      idle(3, 1'b1);
      do_reset(1);
      idle(3, 1'b1);

      // Fetch across a 256-byte boundary.
      cyc(1'b1, 1'b1, 32'h0000_00FC, 1'b1);
      idle(4, 1'b1);

      // PC wrap at 2^32.
      cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
      idle(4, 1'b1);

      // Reset together with a redirect and a pop while full.
      do_reset(1);
      idle(3, 1'b0);
      cyc(1'b0, 1'b1, 32'h20, 1'b1);
      idle(4, 1'b1);

      // Randomized traffic with fresh memory contents.
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      do_reset(1);
      for (int n = 0; n < 3000; n++) begin
         logic        r;
         logic        rv;
         logic        rdy;
         logic [31:0] rpc;
         int          k;
         r   = ($urandom_range(0, 149) != 0);
         rv  = ($urandom_range(0, 14) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         k   = $urandom_range(0, 19);
         rpc = $urandom;
         if (k == 0)      rpc[1:0] = 2'($urandom_range(1, 3));
         else if (k == 1) rpc = 32'hFFFF_FFF4;
         else if (k == 2) rpc = 32'h0000_00F8;
         else             rpc[1:0] = 2'b00;
         cyc(r, rv, rpc, rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
